// File: rtl/vga_timing_gen_if.sv
// Pixel-source and DAC-side signals of the VGA timing generator.
// The generator drives the master modport; the pixel source / display side uses slave.
interface vga_timing_gen_if;
    logic [23:0] color_in;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        frame_start;

    modport master (
        input  color_in,
        output next_x, next_y, vga_clk, vga_hs, vga_vs, vga_blank_n,
        output vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output color_in,
        input  next_x, next_y, vga_clk, vga_hs, vga_vs, vga_blank_n,
        input  vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick at clk_in/2, h/v counters, registered syncs, blanking and colour,
// plus combinational next-pixel lookahead for the colour source. Totals must fit in 10 bits.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk_in,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_ACT_M1 = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        pix_tick_q;
    logic        vga_clk_q;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;
    logic [9:0]  next_row;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Registered outputs describe the pixel at the counters as they stand on the tick edge.
    always_comb begin
        blank_n_d     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_d          = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
        vs_d          = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
        rgb_d         = blank_n_d ? vga.color_in : 24'h0;
        frame_start_d = pix_tick_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pix_tick_q    <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pix_tick_q    <= ~pix_tick_q;
            vga_clk_q     <= ~pix_tick_q;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            if (pix_tick_q) begin
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blank_n_q <= blank_n_d;
                rgb_q     <= rgb_d;
            end
        end
    end

    // Lookahead row follows the line wrap, and reads 0 whenever it falls in vertical blanking.
    always_comb begin
        if (h_cnt_q == H_LAST) begin
            next_row = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end else begin
            next_row = v_cnt_q;
        end
    end

    assign vga.next_x      = (h_cnt_q < H_ACT_M1) ? h_cnt_q + 10'd1 : 10'd0;
    assign vga.next_y      = (next_row < V_ACT) ? next_row : 10'd0;
    assign vga.vga_clk     = vga_clk_q;
    assign vga.vga_hs      = hs_q;
    assign vga.vga_vs      = vs_q;
    assign vga.vga_blank_n = blank_n_q;
    assign vga.vga_r       = rgb_q[23:16];
    assign vga.vga_g       = rgb_q[15:8];
    assign vga.vga_b       = rgb_q[7:0];
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for line timing and a tiny 8x6 raster
// (16 px/line, 11 lines/frame) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    vga_timing_gen_if bus_d ();
    vga_timing_gen_if bus_s ();

    vga_timing_gen dut_d (
        .clk_in  (clk),
        .reset_n (rst_n),
        .vga     (bus_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) dut_s (
        .clk_in  (clk),
        .reset_n (rst_n),
        .vga     (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ticks;
        logic [23:0] color;
        logic [9:0]  nx;
        logic [9:0]  ny;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [23:0] c);
        @(negedge clk);
        rst_n = 1'b0;
        bus_s.color_in = c;
        bus_d.color_in = c;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt [19];

    initial begin
        int n;
        int first_low, low_cnt, vis_cnt, rgb_bad, fall1, fall2;
        int vs_first, vs_cnt, fs_cnt, fs_prev, fs_gap, clk_bad, bnd_bad, fs_wide;
        logic prev_hs;
        logic [23:0] c;
        logic [23:0] exp_rgb;
        checks   = 0;
        failures = 0;

        // ticks = pixel ticks after release; expectations hand-derived for the 16x11 raster
        vt[0]  = '{1,   24'h123456, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{7,   24'hFFFFFF, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{8,   24'h123456, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{9,   24'hFFFFFF, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{11,  24'h123456, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{13,  24'hFFFFFF, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{14,  24'h123456, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{16,  24'hFFFFFF, 10'd1, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{15,  24'h123456, 10'd0, 10'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{6,   24'h123456, 10'd7, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{95,  24'hFFFFFF, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[11] = '{81,  24'h123456, 10'd2, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[12] = '{113, 24'hFFFFFF, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[13] = '{133, 24'h123456, 10'd6, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[14] = '{145, 24'hFFFFFF, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[15] = '{175, 24'h123456, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[16] = '{176, 24'hFFFFFF, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[17] = '{177, 24'h123456, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[18] = '{79,  24'hFFFFFF, 10'd0, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0};

        // reset state
        rst_n = 1'b0;
        bus_s.color_in = 24'hFFFFFF;
        bus_d.color_in = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        chk("rst_hs",    {31'd0, bus_s.vga_hs},      32'd1);
        chk("rst_vs",    {31'd0, bus_s.vga_vs},      32'd1);
        chk("rst_blank", {31'd0, bus_s.vga_blank_n}, 32'd0);
        chk("rst_rgb",   {8'd0, bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}, 32'd0);
        chk("rst_fs",    {31'd0, bus_s.frame_start}, 32'd0);
        chk("rst_vclk",  {31'd0, bus_s.vga_clk},     32'd0);
        chk("rst_hs_d",  {31'd0, bus_d.vga_hs},      32'd1);

        foreach (vt[i]) begin
            do_reset(vt[i].color);
            repeat (2 * vt[i].ticks) @(posedge clk);
            @(negedge clk);
            exp_rgb = vt[i].blank ? vt[i].color : 24'h0;
            chk($sformatf("v%0d_next_x", i), {22'd0, bus_s.next_x}, {22'd0, vt[i].nx});
            chk($sformatf("v%0d_next_y", i), {22'd0, bus_s.next_y}, {22'd0, vt[i].ny});
            chk($sformatf("v%0d_hs", i),     {31'd0, bus_s.vga_hs},      {31'd0, vt[i].hs});
            chk($sformatf("v%0d_vs", i),     {31'd0, bus_s.vga_vs},      {31'd0, vt[i].vs});
            chk($sformatf("v%0d_blank", i),  {31'd0, bus_s.vga_blank_n}, {31'd0, vt[i].blank});
            chk($sformatf("v%0d_fs", i),     {31'd0, bus_s.frame_start}, {31'd0, vt[i].fs});
            chk($sformatf("v%0d_rgb", i),
                {8'd0, bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}, {8'd0, exp_rgb});
        end

        // mid-frame reset while hsync is low, just after a non-tick edge (vga_clk high)
        do_reset(24'hFFFFFF);
        repeat (2 * (16 * 3 + 12) + 1) @(posedge clk);
        #2;
        chk("mid_pre_hs", {31'd0, bus_s.vga_hs}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_hs",     {31'd0, bus_s.vga_hs},  32'd1);
        chk("mid_vclk",   {31'd0, bus_s.vga_clk}, 32'd0);
        chk("mid_next_x", {22'd0, bus_s.next_x},  32'd1);
        chk("mid_next_y", {22'd0, bus_s.next_y},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus_s.frame_start !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_fs_latency", n, 2);

        // two lines on the default 640x480 instance
        do_reset(24'hFFFFFF);
        first_low = -1; low_cnt = 0; vis_cnt = 0; rgb_bad = 0; fall1 = -1; fall2 = -1;
        prev_hs = 1'b1;
        for (int k = 1; k <= 1600; k++) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            if (k <= 800) begin
                if (!bus_d.vga_hs) begin
                    low_cnt++;
                    if (first_low < 0) first_low = k - 1;
                end
                if (bus_d.vga_blank_n) vis_cnt++;
            end
            if (prev_hs && !bus_d.vga_hs) begin
                if (fall1 < 0) fall1 = 2 * k;
                else if (fall2 < 0) fall2 = 2 * k;
            end
            prev_hs = bus_d.vga_hs;
            if (bus_d.vga_blank_n && {bus_d.vga_r, bus_d.vga_g, bus_d.vga_b} != 24'hFFFFFF) rgb_bad++;
            if (!bus_d.vga_blank_n && {bus_d.vga_r, bus_d.vga_g, bus_d.vga_b} != 24'h0) rgb_bad++;
            if (k == 638) chk("la_x_638", {22'd0, bus_d.next_x}, 32'd639);
            if (k == 639) chk("la_x_639", {22'd0, bus_d.next_x}, 32'd0);
            if (k == 799) chk("la_y_799", {22'd0, bus_d.next_y}, 32'd1);
        end
        chk("hs_start",      first_low, 656);
        chk("hs_width",      low_cnt, 96);
        chk("line_visible",  vis_cnt, 640);
        chk("line_period",   fall2 - fall1, 1600);
        chk("line_rgb_bad",  rgb_bad, 0);

        // three frames on the small raster with random colour
        do_reset(24'h0);
        vs_first = -1; vs_cnt = 0; fs_cnt = 0; fs_prev = -1; fs_gap = 0;
        clk_bad = 0; bnd_bad = 0; rgb_bad = 0; fs_wide = 0;
        for (int k = 1; k <= 3 * 176; k++) begin
            c = 24'($urandom);
            bus_s.color_in = c;
            @(posedge clk);
            @(negedge clk);
            if (bus_s.vga_clk !== 1'b1) clk_bad++;
            if (bus_s.frame_start !== 1'b0) fs_wide++;
            @(posedge clk);
            @(negedge clk);
            if (bus_s.vga_clk !== 1'b0) clk_bad++;
            if (bus_s.next_x >= 10'd8 || bus_s.next_y >= 10'd6) bnd_bad++;
            exp_rgb = bus_s.vga_blank_n ? c : 24'h0;
            if ({bus_s.vga_r, bus_s.vga_g, bus_s.vga_b} !== exp_rgb) rgb_bad++;
            if (!bus_s.vga_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = k - 1;
            end
            if (bus_s.frame_start) begin
                fs_cnt++;
                if (fs_prev >= 0) fs_gap = 2 * (k - fs_prev);
                fs_prev = k;
            end
        end
        chk("vs_start",     vs_first, 112);
        chk("vs_total",     vs_cnt, 96);
        chk("fs_count",     fs_cnt, 3);
        chk("fs_period",    fs_gap, 352);
        chk("fs_width",     fs_wide, 0);
        chk("vclk_period",  clk_bad, 0);
        chk("bounds",       bnd_bad, 0);
        chk("frame_rgb",    rgb_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, H_SYNC default 96, H_BP default 48, horizontal porches and sync width in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP, default 10, V_SYNC default 2, V_BP default 33, vertical porches and sync width in lines.
REQ-005 SHALL have port clk_in  input  1  system clock, 50 MHz.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port color_in  input  24  pixel colour {R[7:0],G[7:0],B[7:0]} for coordinate next_x/next_y.
REQ-008 SHALL have port next_x  output  10  column of the pixel displayed at the next pixel tick.
REQ-009 SHALL have port next_y  output  10  row of the pixel displayed at the next pixel tick.
REQ-010 SHALL have port vga_clk  output  1  pixel clock, clk_in/2.
REQ-011 SHALL have port vga_hs, vga_vs  output  1 each  sync pulses, active-low.
REQ-012 SHALL have port vga_blank_n  output  1  high during visible area.
REQ-013 SHALL have port vga_r, vga_g, vga_b  output  8 each  colour to DAC.
REQ-014 SHALL have port frame_start  output  1  one-clk_in pulse at start of each frame.

Function
REQ-015 SHALL toggle internal pix_tick every clk_in; all counter and output updates occur only on clk_in edges with pix_tick=1 (25 MHz pixel rate); vga_clk = registered complement of pix_tick.
REQ-016 SHALL keep h_cnt in 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); increments per tick, wraps to 0.
REQ-017 SHALL keep v_cnt in 0..V_TOTAL-1 (525); increments only when h_cnt wraps; wraps to 0 when both counters at maximum on the same tick.
REQ-018 SHALL drive next_x = h_cnt+1 when h_cnt < H_ACTIVE-1, else 0 (combinational from counters).
REQ-019 SHALL drive next_y = row of next pixel: v_cnt, or v_cnt+1 (0 after V_TOTAL-1) when h_cnt = H_TOTAL-1; forced to 0 when that row >= V_ACTIVE.
REQ-020 SHALL register on each tick: vga_hs low iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vga_vs low iff v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-021 SHALL register vga_blank_n = (h_cnt < H_ACTIVE && v_cnt < V_ACTIVE), aligned with the same tick's sync outputs.
REQ-022 SHALL register vga_r/g/b = color_in when visible per REQ-021, else 0; colour source has one pixel period (2 clk_in) from next_x/next_y change to color_in valid.
REQ-023 SHALL pulse frame_start for exactly one clk_in on the tick where h_cnt=0 and v_cnt=0.
REQ-024 SHALL hold all outputs stable between ticks.
REQ-025 SHALL never let next_x exceed H_ACTIVE-1 or next_y exceed V_ACTIVE-1.

Reset
REQ-026 SHALL on reset_n=0 asynchronously clear h_cnt, v_cnt, pix_tick, vga_clk, frame_start, vga_r/g/b, vga_blank_n; set vga_hs=1, vga_vs=1.
REQ-027 SHALL, after reset release, begin counting on the first clk_in edge; first tick after release treats h_cnt=0,v_cnt=0 and asserts frame_start.
REQ-028 SHALL, on reset mid-frame, restart at pixel (0,0) with no partial sync pulse retained.

Verification
REQ-029 Line timing: run one line -> vga_hs low for exactly 96 ticks starting 656 ticks after line start; line period 1600 clk_in.
REQ-030 Frame timing: run two frames -> vga_vs low for 2 lines starting line 490; frame_start pulses 840000 clk_in apart.
REQ-031 Lookahead: h_cnt=638 -> next_x=639; h_cnt=639 -> next_x=0; h_cnt=799,v_cnt=479 -> next_y=0; h_cnt=799,v_cnt=524 -> next_y=0.
REQ-032 Blanking: color_in=24'hFFFFFF constant -> vga_r/g/b=8'hFF only while vga_blank_n=1, 0 in porches and sync.
REQ-033 Reset mid-frame: assert reset_n=0 at v_cnt=300 -> outputs per REQ-026 immediately; after release next frame_start within 2 clk_in.
REQ-034 Bounds: random run over 3 frames -> next_x<640, next_y<480 always; vga_clk period 2 clk_in.
